gmii_rx_framer: RTL and testbench
=================================

GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

Interface
REQ-001 SHALL have parameter MIN_PREAMBLE, default 1: minimum count of 0x55 bytes required before SFD.
REQ-002 SHALL have parameter LEN_W, default 11: width of the frame length counter.
REQ-003 SHALL have port clk, input, 1: GMII receive clock; the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-005 SHALL have port gmii_rxd, input, 8: receive byte from the RGMII receive stage.
REQ-006 SHALL have port gmii_rx_dv, input, 1: receive data valid.
REQ-007 SHALL have port gmii_rx_er, input, 1: receive error.
REQ-008 SHALL have port out_data, output, 8: payload byte, i.e. destination MAC through FCS.
REQ-009 SHALL have port out_valid, output, 1: out_data strobe.
REQ-010 SHALL have port out_first, output, 1: first payload byte of the frame.
REQ-011 SHALL have port out_last, output, 1: last payload byte of the frame.
REQ-012 SHALL have port out_err, output, 1: frame error, qualified by out_last.
REQ-013 SHALL have port frame_len, output, LEN_W: payload byte count, qualified by out_last.
REQ-014 SHALL have port good_cnt, output, 8: count of frames ending with out_err=0, wrapping.
REQ-015 SHALL have port bad_cnt, output, 8: count of aborted or errored frames, wrapping.

Function
REQ-016 SHALL implement the states IDLE, PREAMBLE, DATA and DROP.
REQ-017 IDLE SHALL behave as follows:
- dv=1 & rxd=0x55 -> PREAMBLE, preamble count=1.
- dv=1 & any other byte -> DROP.
- dv=0 -> stay in IDLE.
REQ-018 PREAMBLE SHALL behave as follows:
- 0x55 -> increment the preamble count, saturating at 15.
- 0xD5 with count>=MIN_PREAMBLE -> DATA.
- 0xD5 with count<MIN_PREAMBLE, or any other byte -> DROP, bad_cnt+1.
- dv=0 -> IDLE, no counter change.
REQ-019 DATA SHALL behave as follows:
- Each dv=1 byte is a payload byte.
- dv=0 -> IDLE; the frame ends on the previous byte.
REQ-020 DROP SHALL ignore all bytes and SHALL return to IDLE on the first cycle with dv=0.
REQ-021 Preamble and SFD bytes SHALL never appear on out_data.
REQ-022 Payload byte latency SHALL be fixed at exactly 2 clk cycles from its gmii_rxd cycle to its out_valid cycle; the implementation uses a one-byte holding register so the final byte can be tagged.
REQ-023 out_valid SHALL be high for exactly one cycle per payload byte; payload bytes SHALL be contiguous, with no gaps inside a frame.
REQ-024 out_first SHALL accompany the first payload byte only.
REQ-025 out_last SHALL accompany the byte whose following input cycle has dv=0.
REQ-026 A single-byte payload SHALL assert out_first and out_last together.
REQ-027 Any gmii_rx_er=1 while dv=1 in DATA SHALL set a sticky error, reported as out_err=1 with out_last.
REQ-028 gmii_rx_er with dv=0 (carrier extension or false carrier) SHALL be ignored.
REQ-029 frame_len SHALL count payload bytes, saturating at 2^LEN_W-1.
REQ-030 Saturation of frame_len SHALL force out_err=1 for that frame.
REQ-031 On out_last, exactly one of good_cnt or bad_cnt SHALL increment: good_cnt when out_err=0, bad_cnt otherwise.
REQ-032 A frame ending zero bytes after SFD (dv falls directly after 0xD5) SHALL produce no output and SHALL increment bad_cnt.
REQ-033 out_err and frame_len SHALL hold their last values between frames; they are only meaningful with out_last.
REQ-034 A new preamble arriving one cycle after dv falls (minimum gap) SHALL be accepted, while the prior frame's out_last is still draining.

Reset
REQ-035 While rst=1, the block SHALL force: state IDLE, out_valid=0, out_first=0, out_last=0, out_err=0, out_data=0, frame_len=0, good_cnt=0, bad_cnt=0, holding register empty.
REQ-036 After rst deasserts, the block SHALL be disarmed until gmii_rx_dv=0 has been seen for at least one cycle; while disarmed, a frame in progress SHALL be ignored entirely, with no output and no counter change.
REQ-037 Reset asserted mid-frame SHALL discard the held byte; no out_last SHALL be emitted for the truncated frame.

Verification
REQ-038 Bench SHALL drive 7x0x55, 0xD5, 64 payload bytes 0x00..0x3F, then dv low, and SHALL check:
- 64 out_valid pulses, the first 2 cycles after the first payload byte;
- out_first on 0x00, out_last on 0x3F;
- frame_len=64, out_err=0, good_cnt=1.
REQ-039 Bench SHALL drive 0x55, 0x55, 0xA5, 10 bytes and check: no out_valid, bad_cnt=1, DROP held until dv low.
REQ-040 Bench SHALL drive a 20-byte payload with rx_er=1 on byte 5 and check: 20 bytes out, out_err=1 with out_last, bad_cnt=1, good_cnt=0.
REQ-041 Bench SHALL drive back-to-back frames with a 1-cycle dv gap (3 bytes, then 2 bytes) and check: out_last for frame 1 then out_first for frame 2 with no lost byte, good_cnt=2.
REQ-042 Bench SHALL pulse rst while byte 10 of a frame is in flight and check: outputs zero, no out_last, remaining bytes ignored, next frame fully received.
REQ-043 Bench SHALL drive MIN_PREAMBLE=1 with a single 0x55 + 0xD5 + 1 byte, and check out_first=out_last=1 and frame_len=1; then SFD followed immediately by dv low, and check bad_cnt+1.

Source files
------------

// File: rtl/gmii_rx_framer.sv
// GMII receive framer.
// Strips preamble and SFD, then emits payload bytes (destination MAC through
// FCS) with first/last tags. It also reports the frame length and error status,
// and keeps wrapping good/bad frame counters.
//
// Ports:
//   clk, rst             - receive clock; synchronous active-high reset
//   gmii_rxd/_rx_dv/_rx_er - GMII receive byte, data valid, receive error
//   out_data/out_valid   - payload byte stream, two cycles after gmii_rxd
//   out_first/out_last   - frame delimiters on the payload stream
//   out_err, frame_len   - frame status, meaningful only with out_last
//   good_cnt, bad_cnt    - wrapping frame counters
module gmii_rx_framer #(
    parameter int unsigned MIN_PREAMBLE = 1,
    parameter int unsigned LEN_W        = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       gmii_rxd,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             out_err,
    output logic [LEN_W-1:0] frame_len,
    output logic [7:0]       good_cnt,
    output logic [7:0]       bad_cnt
);

    localparam logic [7:0]       PRE_BYTE = 8'h55;
    localparam logic [7:0]       SFD_BYTE = 8'hD5;
    localparam logic [3:0]       PRE_MAX  = 4'hF;
    localparam logic [LEN_W-1:0] LEN_MAX  = '1;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t           state_q, state_d;
    logic             armed_q, armed_d;
    logic [3:0]       pre_cnt_q, pre_cnt_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic             hold_valid_q, hold_valid_d;
    logic             hold_first_q, hold_first_d;
    logic             err_q, err_d;
    logic             sat_q, sat_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [7:0]       out_data_d;
    logic             out_valid_d, out_first_d, out_last_d, out_err_d;
    logic [LEN_W-1:0] frame_len_d;
    logic [7:0]       good_cnt_d, bad_cnt_d;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        pre_cnt_d    = pre_cnt_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        hold_first_d = hold_first_q;
        err_d        = err_q;
        sat_d        = sat_q;
        len_d        = len_q;
        out_data_d   = out_data;
        out_valid_d  = 1'b0;
        out_first_d  = 1'b0;
        out_last_d   = 1'b0;
        out_err_d    = out_err;
        frame_len_d  = frame_len;
        good_cnt_d   = good_cnt;
        bad_cnt_d    = bad_cnt;

        if (!armed_q) begin
            // After reset, wait for an inter-frame gap so a frame already in
            // progress is never picked up halfway through.
            state_d = IDLE;
            if (!gmii_rx_dv) begin
                armed_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == PRE_BYTE) begin
                            state_d   = PREAMBLE;
                            pre_cnt_d = 4'd1;
                        end else begin
                            state_d = DROP;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_d = IDLE;
                    end else if (gmii_rxd == PRE_BYTE) begin
                        if (pre_cnt_q != PRE_MAX) begin
                            pre_cnt_d = pre_cnt_q + 4'd1;
                        end
                    end else if (gmii_rxd == SFD_BYTE &&
                                 32'(pre_cnt_q) >= MIN_PREAMBLE) begin
                        state_d      = DATA;
                        hold_valid_d = 1'b0;
                        err_d        = 1'b0;
                        sat_d        = 1'b0;
                        len_d        = '0;
                    end else begin
                        state_d   = DROP;
                        bad_cnt_d = bad_cnt + 8'd1;
                    end
                end

                DATA: begin
                    if (gmii_rx_dv) begin
                        // A held byte that is followed by another valid byte
                        // is not the last one, so it can be released untagged.
                        if (hold_valid_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hold_data_q;
                            out_first_d = hold_first_q;
                        end
                        hold_data_d  = gmii_rxd;
                        hold_valid_d = 1'b1;
                        hold_first_d = !hold_valid_q;
                        err_d        = err_q | gmii_rx_er;
                        // A byte arriving with the length already at its
                        // maximum makes the reported length wrong.
                        if (len_q == LEN_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            len_d = len_q + LEN_W'(1);
                        end
                    end else begin
                        state_d      = IDLE;
                        hold_valid_d = 1'b0;
                        if (hold_valid_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hold_data_q;
                            out_first_d = hold_first_q;
                            out_last_d  = 1'b1;
                            out_err_d   = err_q | sat_q;
                            frame_len_d = len_q;
                            if (err_q | sat_q) begin
                                bad_cnt_d = bad_cnt + 8'd1;
                            end else begin
                                good_cnt_d = good_cnt + 8'd1;
                            end
                        end else begin
                            // The SFD was followed directly by the end of the frame.
                            bad_cnt_d = bad_cnt + 8'd1;
                        end
                    end
                end

                DROP: begin
                    if (!gmii_rx_dv) begin
                        state_d = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            pre_cnt_q    <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            hold_first_q <= 1'b0;
            err_q        <= 1'b0;
            sat_q        <= 1'b0;
            len_q        <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_first    <= 1'b0;
            out_last     <= 1'b0;
            out_err      <= 1'b0;
            frame_len    <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            pre_cnt_q    <= pre_cnt_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            hold_first_q <= hold_first_d;
            err_q        <= err_d;
            sat_q        <= sat_d;
            len_q        <= len_d;
            out_data     <= out_data_d;
            out_valid    <= out_valid_d;
            out_first    <= out_first_d;
            out_last     <= out_last_d;
            out_err      <= out_err_d;
            frame_len    <= frame_len_d;
            good_cnt     <= good_cnt_d;
            bad_cnt      <= bad_cnt_d;
        end
    end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed testbench for gmii_rx_framer with an expected-byte scoreboard.
module tb_gmii_rx_framer;

    localparam int unsigned LEN_W = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       gmii_rxd = 8'h00;
    logic             gmii_rx_dv = 1'b0;
    logic             gmii_rx_er = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid, out_first, out_last, out_err;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       good_cnt, bad_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_good = 0;
    int exp_bad  = 0;

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
        logic       e;
        int         len;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    gmii_rx_framer #(.MIN_PREAMBLE(1), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_err    (out_err),
        .frame_len  (frame_len),
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one input cycle; the byte is sampled at the next rising edge.
    task automatic step(input logic dv, input logic er, input logic [7:0] d);
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic f, input logic l,
                        input logic e, input int len);
        exp_t x;
        x.d = d; x.f = f; x.l = l; x.e = e; x.len = len; x.cyc = cyc + 2;
        exp_q.push_back(x);
    endtask

    // Preamble, SFD, payload base..base+n-1, then one dv-low cycle carrying rx_er.
    task automatic send_frame(input int npre, input int n, input int base, input int er_idx);
        for (int i = 0; i < npre; i++) step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < n; i++) begin
            push(8'(base + i), i == 0, i == n - 1, er_idx >= 0, n);
            step(1'b1, i == er_idx, 8'(base + i));
        end
        step(1'b0, 1'b1, 8'hF0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_good_cnt"}, 32'(good_cnt), 32'(8'(exp_good)));
        check({tag, "_bad_cnt"},  32'(bad_cnt),  32'(8'(exp_bad)));
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data",  32'(out_data),  32'(e.d));
                check("out_first", 32'(out_first), 32'(e.f));
                check("out_last",  32'(out_last),  32'(e.l));
                check("latency",   32'(cyc),       32'(e.cyc));
                if (e.l) begin
                    check("out_err",   32'(out_err),   32'(e.e));
                    check("frame_len", 32'(frame_len), 32'(e.len));
                end
            end
        end
    end

    initial begin
        // Reset values
        idle(3);
        check("rst_valid",     32'(out_valid), 32'd0);
        check("rst_first",     32'(out_first), 32'd0);
        check("rst_last",      32'(out_last),  32'd0);
        check("rst_err",       32'(out_err),   32'd0);
        check("rst_data",      32'(out_data),  32'd0);
        check("rst_frame_len", 32'(frame_len), 32'd0);
        check_counters("rst");
        rst = 1'b0;
        idle(2);

        // 64-byte frame after a 7-byte preamble
        send_frame(7, 64, 8'h00, -1);
        idle(4);
        exp_good++;
        check_counters("f64");
        check("f64_frame_len", 32'(frame_len), 32'd64);
        check("f64_out_err",   32'(out_err),   32'd0);
        check("f64_drained",   32'(exp_q.size()), 32'd0);

        // Bad preamble byte; DROP must ignore a later preamble+SFD inside the burst
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hA5);
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        idle(4);
        exp_bad++;
        check_counters("drop");

        // rx_er on payload byte 5 (index 4)
        send_frame(7, 20, 8'h40, 4);
        idle(4);
        exp_bad++;
        check_counters("rxer");
        check("rxer_out_err", 32'(out_err), 32'd1);

        // Back-to-back frames with the minimum one-cycle gap
        send_frame(7, 3, 8'hB0, -1);
        send_frame(2, 2, 8'hC0, -1);
        idle(4);
        exp_good += 2;
        check_counters("b2b");
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Single 0x55, SFD, one byte
        send_frame(1, 1, 8'hA7, -1);
        idle(3);
        exp_good++;
        check("one_frame_len", 32'(frame_len), 32'd1);
        check_counters("one");

        // SFD followed directly by dv low
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        idle(4);
        exp_bad++;
        check_counters("empty");

        // Reset while payload byte 10 is in flight; bytes 0..8 are already out
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 10; i++) begin
            if (i <= 8) push(8'(8'h80 + i), i == 0, 1'b0, 1'b0, 0);
            step(1'b1, 1'b0, 8'(8'h80 + i));
        end
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h8A);
        exp_good = 0;
        exp_bad  = 0;
        check("mid_rst_valid",     32'(out_valid), 32'd0);
        check("mid_rst_last",      32'(out_last),  32'd0);
        check("mid_rst_data",      32'(out_data),  32'd0);
        check("mid_rst_frame_len", 32'(frame_len), 32'd0);
        check_counters("mid_rst");
        step(1'b1, 1'b0, 8'h8B);
        rst = 1'b0;
        // Still the truncated frame: disarmed, so preamble-looking bytes are ignored
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        step(1'b1, 1'b0, 8'h33);
        idle(2);
        check_counters("disarmed");
        send_frame(2, 5, 8'h90, -1);
        idle(4);
        exp_good++;
        check_counters("after_rst");
        check("after_rst_frame_len", 32'(frame_len), 32'd5);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
